// File: rtl/inst_fetch.sv
// inst_fetch: in-order instruction fetch with a DEPTH-entry circular buffer,
// redirect flushing, and dropping of stale memory responses.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus_4_if
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] word_q [DEPTH];
  logic [AW-1:0] head, tail, fptr;
  logic [AW:0] count, pend;
  logic [AW+1:0] drop, inflight;
  logic [31:0] fetch_pc;
  logic pop, fill, issue;
  // Entries fill in order, so the head is filled exactly when some entry is.
  always_comb begin
    inflight = drop + (AW+2)'(pend);
    if_valid = count != pend;
    pop = if_valid && !stall;
    issue = !rst && !redirect_valid && (count != (AW+1)'(DEPTH) || pop)
            && inflight != (AW+2)'(2 * DEPTH);
    fill = imem_rvalid && drop == '0 && pend != '0;
    imem_req = issue;
    imem_addr = fetch_pc;
    instruction = if_valid ? word_q[head] : 32'h0000_0013;
    pc_if = if_valid ? pc_q[head] : 32'h0;
    pc_plus_4_if = pc_if + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head <= '0;
      tail <= '0;
      fptr <= '0;
      count <= '0;
      pend <= '0;
      drop <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head <= '0;
      tail <= '0;
      fptr <= '0;
      count <= '0;
      pend <= '0;
      drop <= inflight - (AW+2)'(imem_rvalid && inflight != '0);
    end else begin
      if (issue) begin
        pc_q[tail] <= fetch_pc;
        tail <= tail + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (fill) begin
        word_q[fptr] <= imem_rdata;
        fptr <= fptr + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(issue) - (AW+1)'(pop);
      pend <= pend + (AW+1)'(issue) - (AW+1)'(fill);
      if (imem_rvalid && drop != '0) drop <= drop - (AW+2)'(1);
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: vector table, directed corner sequences and a randomized
// run scored against an in-order program-stream model.
module tb_inst_fetch;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_rvalid, redirect_valid, stall, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, pc_if, pc_plus_4_if;
  logic req2, rv2 = 1'b0, v2, zero = 1'b0;
  logic [31:0] addr2, rd2 = 32'h0, ins2, pc2, p42;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic s; logic q; logic [31:0] a; logic v; logic [31:0] p; } vec_t;
  mreq_t mq[$];
  vec_t tab[12];
  int cyc = 0, lat_lo = 1, lat_hi = 1, total = 0, passed = 0;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .instruction(instruction), .pc_if(pc_if),
    .pc_plus_4_if(pc_plus_4_if));

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rv2), .imem_rdata(rd2),
    .redirect_valid(zero), .redirect_pc(32'h0), .stall(zero),
    .if_valid(v2), .instruction(ins2), .pc_if(pc2), .pc_plus_4_if(p42));

  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h0010_0093 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    rv2 <= !rst && req2;
    rd2 <= w(addr2);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp);
    stall = s;
    redirect_valid = r;
    redirect_pc = rp;
    imem_rvalid = mq.size() > 0 && mq[0].due <= cyc;
    imem_rdata = imem_rvalid ? w(mq[0].addr) : 32'hDEAD_BEEF;
    @(negedge clk);
  endtask

  task automatic adv();
    logic q, rv;
    logic [31:0] a;
    int d;
    q = imem_req;
    a = imem_addr;
    rv = imem_rvalid;
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (rv) void'(mq.pop_front());
      if (q) begin
        d = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (mq.size() > 0 && mq[$].due > d) d = mq[$].due;
        mq.push_back('{a, d});
      end
    end
    cyc++;
    #1;
  endtask

  task automatic check_idle(input string n);
    chk({n, "_valid"}, if_valid, 0);
    chk({n, "_instr"}, instruction, 32'h13);
    chk({n, "_pc"}, pc_if, 0);
    chk({n, "_pc4"}, pc_plus_4_if, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0);
    adv();
    drive(0, 0, 0);
    check_idle("reset");
    chk("reset_req", imem_req, 0);
    adv();
    rst = 1'b0;
  endtask

  task automatic expect_first(input string n, input logic [31:0] p);
    int k = 0;
    drive(0, 0, 0);
    while (!if_valid && k < 20) begin
      adv();
      drive(0, 0, 0);
      k++;
    end
    chk({n, "_valid"}, if_valid, 1);
    chk({n, "_pc"}, pc_if, p);
    chk({n, "_instr"}, instruction, w(p));
    adv();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic s, r;
    logic [31:0] rp, exp_iss, exp_pop;
    int pops;
    tab[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tab[1]  = '{1'b0, 1'b1, 32'd4,  1'b0, 32'd0};
    tab[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
    tab[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd4};
    for (int i = 4; i < 9; i++) tab[i] = '{1'b1, 1'b0, 32'd0, 1'b1, 32'd8};
    tab[9]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd8};
    tab[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd12};
    tab[11] = '{1'b0, 1'b1, 32'd24, 1'b1, 32'd16};
    stall = 0; redirect_valid = 0; redirect_pc = 0; imem_rvalid = 0; imem_rdata = 0;

    // Streaming, stall hold and RESET_PC wrap on the second instance.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tab[i].s, 0, 0);
      chk($sformatf("tab%0d_req", i), imem_req, tab[i].q);
      if (tab[i].q) chk($sformatf("tab%0d_addr", i), imem_addr, tab[i].a);
      chk($sformatf("tab%0d_valid", i), if_valid, tab[i].v);
      chk($sformatf("tab%0d_pc", i), pc_if, tab[i].p);
      chk($sformatf("tab%0d_pc4", i), pc_plus_4_if, tab[i].p + 4);
      chk($sformatf("tab%0d_instr", i), instruction, tab[i].v ? w(tab[i].p) : 32'h13);
      if (i < 3) chk($sformatf("wrap%0d_addr", i), addr2, 32'hFFFF_FFF8 + 32'(4 * i));
      if (i == 3) begin
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4", p42, 32'h0);
      end
      adv();
    end

    // Redirect plus stall in the same cycle as a response.
    drive(1, 1, 32'h100);
    chk("rs_req", imem_req, 0);
    adv();
    drive(0, 0, 0);
    check_idle("rs_flush");
    chk("rs_addr", imem_addr, 32'h100);
    adv();
    expect_first("rs_first", 32'h100);

    // Redirect with two requests outstanding on a 3-cycle memory.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); adv();
    drive(0, 1, 32'h43);
    chk("rd_req", imem_req, 0);
    adv();
    drive(0, 0, 0);
    chk("rd_req2", imem_req, 1);
    chk("rd_addr", imem_addr, 32'h40);
    adv();
    expect_first("rd_first", 32'h40);
    expect_first("rd_second", 32'h44);

    // Reset with a full buffer and two requests in flight.
    do_reset();
    drive(0, 0, 0); adv();
    drive(0, 0, 0); adv();
    rst = 1'b1;
    drive(0, 0, 0);
    chk("rf_full_req", imem_req, 0);
    adv();
    rst = 1'b0;
    drive(0, 0, 0);
    check_idle("rf_post");
    chk("rf_req", imem_req, 1);
    chk("rf_addr", imem_addr, 32'h0);
    adv();
    expect_first("rf_first", 32'h0);

    // Randomized stall/redirect/latency against the program-stream model.
    lat_lo = 1; lat_hi = 4;
    do_reset();
    exp_iss = 0; exp_pop = 0; pops = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom % 4) == 0;
      r = ($urandom % 32) == 0;
      rp = $urandom;
      drive(s, r, rp);
      if (r) chk("rnd_redir_noissue", imem_req, 0);
      if (imem_req) chk("rnd_addr", imem_addr, exp_iss);
      if (if_valid && !s && !r) begin
        chk("rnd_pc", pc_if, exp_pop);
        chk("rnd_instr", instruction, w(exp_pop));
        chk("rnd_pc4", pc_plus_4_if, exp_pop + 4);
        exp_pop += 4;
        pops++;
      end
      if (!if_valid) chk("rnd_idle_instr", instruction, 32'h13);
      chk("rnd_inflight", 32'(mq.size() <= 2 * DEPTH), 1);
      if (r) begin
        exp_iss = {rp[31:2], 2'b00};
        exp_pop = exp_iss;
      end else if (imem_req) exp_iss += 4;
      adv();
    end
    chk("rnd_progress", 32'(pops > 200), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2: number of fetch-buffer entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  fetch request, valid this cycle.
REQ-006 imem_addr  output  32  byte address of the request, always 4-byte aligned.
REQ-007 imem_rvalid  input  1  response valid; responses return in order, at least 1 cycle after the request.
REQ-008 imem_rdata  input  32  instruction word for the oldest outstanding request.
REQ-009 redirect_valid  input  1  branch or jump taken from DecEx.
REQ-010 redirect_pc  input  32  target byte address.
REQ-011 stall  input  1  DecEx cannot accept an instruction this cycle.
REQ-012 if_valid  output  1  instruction, pc_if and pc_plus_4_if are valid.
REQ-013 instruction  output  32  fetched instruction word to DecEx.
REQ-014 pc_if  output  32  byte address of the presented instruction.
REQ-015 pc_plus_4_if  output  32  pc_if + 4, modulo 2^32.

Function
REQ-016 The fetch buffer SHALL be an in-order circular buffer of DEPTH entries, each holding {pc, word, filled}.
REQ-017 Issue: the block SHALL drive imem_req=1 when a free entry exists and redirect_valid=0.
- On issue, an entry is allocated with pc=fetch_pc and filled=0.
- fetch_pc advances by 4 and wraps at 2^32.
REQ-018 imem_addr SHALL equal fetch_pc whenever imem_req=1.
REQ-019 Response: on imem_rvalid=1 with drop_cnt=0, imem_rdata SHALL be written to the oldest unfilled entry and that entry marked filled.
REQ-020 if_valid SHALL be 1 exactly when the head entry is filled.
- Outputs are driven from the head entry, so a response becomes visible the cycle after imem_rvalid.
REQ-021 Pop: the head entry SHALL be freed on a clock edge where if_valid=1 and stall=0.
- A freed entry is reusable for an issue in the same cycle.
REQ-022 While if_valid=0, outputs SHALL be instruction=32'h0000_0013 (NOP), pc_if=0 and pc_plus_4_if=4.
REQ-023 While stall=1, all outputs SHALL hold their values.
REQ-024 Redirect: on a clock edge with redirect_valid=1, the block SHALL do all of the following:
- flush every buffer entry;
- set fetch_pc to {redirect_pc[31:2],2'b00};
- set drop_cnt to the number of requests issued but not yet responded to, not counting any response arriving in the same cycle;
- issue nothing in that cycle.
REQ-025 Redirect SHALL take priority over stall, pop and fill in the same cycle; a response arriving in the redirect cycle SHALL be discarded.
REQ-026 While drop_cnt>0, each imem_rvalid SHALL decrement drop_cnt and discard imem_rdata.
- Issue of the new stream proceeds in parallel.
- New-stream responses are accepted only once drop_cnt=0.
REQ-027 The count of outstanding plus buffered requests SHALL never exceed DEPTH.
- Combined with drop_cnt, in-flight memory requests SHALL never exceed 2*DEPTH.
REQ-028 Full buffer: imem_req=0 until a pop frees an entry.
- Empty buffer: if_valid=0 with no bubble beyond the memory latency.
REQ-029 imem_rvalid=1 with no outstanding request is a protocol violation and SHALL be ignored.

Reset
REQ-030 On rst=1 at a clock edge, the block SHALL reset to:
- fetch_pc=RESET_PC;
- buffer empty;
- drop_cnt=0;
- imem_req=0 in the following cycle;
- if_valid=0, instruction=32'h0000_0013, pc_if=0, pc_plus_4_if=4.
REQ-031 Reset mid-operation SHALL discard all in-flight state; responses to pre-reset requests are not dropped, so the bench SHALL reset the memory model together with the block.
REQ-032 The first request after reset SHALL issue in the first cycle with rst=0, with imem_addr=RESET_PC.

Verification
REQ-033 Reset release, 1-cycle memory holding word i = 32'h0010_0093+i, no stall -> addresses 0,4,8,...; if_valid from cycle 3; one instruction per cycle with pc_if 0,4,8 and pc_plus_4_if 4,8,12.
REQ-034 stall held 5 cycles at pc_if=8 -> outputs frozen at pc_if=8; imem_req drops once DEPTH entries are held; on release, pc_if=12 next cycle with no lost or duplicated word.
REQ-035 redirect_pc=32'h0000_0043 with 2 requests outstanding -> next imem_addr=32'h40; two stale responses discarded; first if_valid shows pc_if=32'h40.
REQ-036 redirect_valid and stall asserted in the same cycle as imem_rvalid -> that response is discarded; the buffer empties; the stream resumes at the target.
REQ-037 RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus_4_if=0 at pc_if=FFFF_FFFC.
REQ-038 rst asserted while 2 requests are in flight and the buffer is full -> next cycle if_valid=0 and outputs at their reset values; fetch restarts at RESET_PC.
